// File: rtl/rr_load_arbiter_pkg.sv
// rr_load_arbiter_pkg
//   Shared types and helpers for the round-robin load arbiter.
//   arb_state_t : arbiter mode (open round-robin vs. locked burst to one owner)
//   idx_w()     : bit width needed to index n items, never less than 1
package rr_load_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // $clog2(1) and $clog2(2) would give 0 and 1; a zero-width index is illegal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_load_arbiter_if.sv
// rr_load_arbiter_if
//   Bundle between the register-write clients and the shared holding register.
//   req     : per-requester load request, held until granted
//   lock    : per-requester burst request, only meaningful together with req
//   data    : requester data, slice i = data[i*WIDTH +: WIDTH]
//   gnt     : one-hot grant, combinational, same cycle as the load
//   q       : shared register contents
//   q_valid : one-cycle pulse, q was loaded on the previous edge
//   q_src   : index of the requester whose data sits in q
//   modport master : client side     modport slave : arbiter side
interface rr_load_arbiter_if
    import rr_load_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();
    localparam int IDX_W = idx_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [IDX_W-1:0]      q_src;

    modport master (
        output req, lock, data,
        input  gnt, q, q_valid, q_src
    );

    modport slave (
        input  req, lock, data,
        output gnt, q, q_valid, q_src
    );
endinterface

// File: rtl/rr_load_arbiter_pick.sv
// rr_load_arbiter_pick (rr_pick)
//   Combinational rotate-priority encoder. Scans i_req starting at i_ptr,
//   wrapping past NREQ-1 back to 0, and reports the first set bit.
//   i_req    : request vector
//   i_ptr    : index with highest priority this cycle
//   o_valid  : at least one request is set
//   o_idx    : index of the winner (0 when none)
//   o_onehot : winner as a one-hot vector (all zero when none)
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [NREQ-1:0]  o_onehot
);
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        o_valid = 1'b0;
        o_idx   = '0;
        // Walk from the farthest offset toward the pointer so the last hit,
        // the one closest to the pointer, is the one that sticks.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(i_ptr) + k) % NREQ;
            if (i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(cand);
            end
        end
        o_onehot = NREQ'(o_valid) << o_idx;
    end
endmodule

// File: rtl/rr_load_arbiter.sv
// rr_load_arbiter
//   Round-robin arbiter sharing one load-on-enable data register among NREQ
//   requesters. One requester is granted per cycle and its data is loaded on
//   the edge that ends that cycle. A granted requester holding lock keeps the
//   register for up to MAX_BURST grants plus one final beat.
//   clk    : clock, all state on the rising edge
//   rst    : synchronous reset, active low
//   io_bus : slave side of rr_load_arbiter_if (req/lock/data in,
//            gnt/q/q_valid/q_src out)
module rr_load_arbiter
    import rr_load_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    rr_load_arbiter_if.slave io_bus
);
    localparam int IDX_W = idx_w(NREQ);
    localparam int CNT_W = idx_w(MAX_BURST + 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [IDX_W-1:0] r_q_src;

    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NREQ-1:0]  w_gnt;
    logic             w_load;
    logic [IDX_W-1:0] w_sel;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [NREQ-1:0]  w_pick_onehot;
    logic             w_burst_go;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (io_bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    // Owner keeps the register only while it still asks, still locks and has
    // beats left; otherwise this cycle is the exit cycle.
    assign w_burst_go = io_bus.req[r_owner] && io_bus.lock[r_owner]
                     && (r_cnt < CNT_W'(MAX_BURST));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so it sits inside the
        // clocked branch rather than in the sensitivity list.
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    if (io_bus.lock[w_pick_idx]) begin
                        // Pointer stays put: it advances past the owner at exit.
                        w_state_nxt = ARB_BURST;
                        w_owner_nxt = w_pick_idx;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        w_ptr_nxt = next_idx(w_pick_idx);
                    end
                end
            end
            ARB_BURST: begin
                if (w_burst_go) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = next_idx(r_owner);
                    w_cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    // Output logic: Mealy grant and load select.
    always_comb begin
        w_gnt = '0;
        w_sel = '0;
        if (rst) begin
            unique case (r_state)
                ARB_IDLE: begin
                    w_gnt = w_pick_onehot;
                    w_sel = w_pick_idx;
                end
                ARB_BURST: begin
                    // Continuing beats and the final beat both go to the owner
                    // whenever it still requests; lock is irrelevant here.
                    w_gnt[r_owner] = io_bus.req[r_owner];
                    w_sel          = r_owner;
                end
                default: ;
            endcase
        end
    end

    assign w_load = |w_gnt;

    // Shared holding register with load enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_src   <= '0;
        end else begin
            r_q_valid <= w_load;
            if (w_load) begin
                r_q     <= io_bus.data[int'(w_sel) * WIDTH +: WIDTH];
                r_q_src <= w_sel;
            end
        end
    end

    assign io_bus.gnt     = w_gnt;
    assign io_bus.q       = r_q;
    assign io_bus.q_valid = r_q_valid;
    assign io_bus.q_src   = r_q_src;

endmodule
